// File: rtl/if_id_fetch_stage.sv
// Instruction fetch stage and IF/ID pipeline register for the 16-bit TSC CPU.
// Owns the PC, issues requests to a variable-latency instruction memory over a
// request/ready handshake, and loads fetched words into IF/ID. Honours stall,
// redirect (branch/jump/flush) and halt.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   FETCH     | request outstanding at pc; load IF/ID when the word arrives
//   HOLD      | word arrived under stall; parked in hold buffer, no request
//   SQUASH    | a flushed request is still in flight at req_addr; drop it
//   HALTED    | HLT seen; no requests, PC frozen, only reset exits
module if_id_fetch_stage #(
   parameter int                 WORD_W      = 16,
   parameter logic [WORD_W-1:0]  RESET_PC    = '0,
   parameter logic [WORD_W-1:0]  BUBBLE_INST = WORD_W'(16'hF01C)
) (
   input  logic                clk,
   input  logic                reset_n,
   output logic                i_readM,
   output logic [WORD_W-1:0]   i_address,
   input  logic [WORD_W-1:0]   i_data,
   input  logic                i_ready,
   input  logic                stall,
   input  logic                redirect_valid,
   input  logic [WORD_W-1:0]   redirect_pc,
   input  logic                halt,
   output logic [WORD_W-1:0]   if_id_inst,
   output logic [WORD_W-1:0]   if_id_pc_plus1,
   output logic                if_id_valid,
   output logic [15:0]         fetch_count,
   output logic                halted
);

   typedef enum logic [1:0] {
      ST_FETCH  = 2'd0,
      ST_HOLD   = 2'd1,
      ST_SQUASH = 2'd2,
      ST_HALTED = 2'd3
   } state_t;

   state_t              state;
   state_t              state_nxt;

   logic [WORD_W-1:0]   pc;
   logic [WORD_W-1:0]   pc_plus1;
   logic [WORD_W-1:0]   req_addr;
   logic                halt_pending;
   logic [WORD_W-1:0]   hold_inst;
   logic [WORD_W-1:0]   hold_pc1;

   assign pc_plus1 = pc + WORD_W'(1);

   // State register; reset is sampled on the clock edge.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= ST_FETCH;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode; priority is redirect > halt > ready/stall.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_FETCH: begin
            if (redirect_valid) begin
               state_nxt = i_ready ? ST_FETCH : ST_SQUASH;
            end else if (halt) begin
               state_nxt = i_ready ? ST_HALTED : ST_SQUASH;
            end else if (i_ready && stall) begin
               state_nxt = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (redirect_valid) begin
               state_nxt = ST_FETCH;
            end else if (halt) begin
               state_nxt = ST_HALTED;
            end else if (!stall) begin
               state_nxt = ST_FETCH;
            end
         end
         ST_SQUASH: begin
            // The squashed request must run to completion before anything
            // else is issued, since the memory needs a stable address.
            if (i_ready) begin
               if (redirect_valid) begin
                  state_nxt = ST_FETCH;
               end else if (halt_pending || halt) begin
                  state_nxt = ST_HALTED;
               end else begin
                  state_nxt = ST_FETCH;
               end
            end
         end
         ST_HALTED: begin
            state_nxt = ST_HALTED;
         end
         default: begin
            state_nxt = ST_FETCH;
         end
      endcase
   end

   // Memory request outputs; a squashed request keeps its original address.
   always_comb begin
      i_readM   = reset_n & ((state == ST_FETCH) | (state == ST_SQUASH));
      i_address = (state == ST_SQUASH) ? req_addr : pc;
      halted    = (state == ST_HALTED);
   end

   // PC, IF/ID, hold buffer, squash bookkeeping and delivered-instruction count.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pc             <= RESET_PC;
         req_addr       <= '0;
         halt_pending   <= 1'b0;
         hold_inst      <= '0;
         hold_pc1       <= '0;
         if_id_inst     <= BUBBLE_INST;
         if_id_pc_plus1 <= '0;
         if_id_valid    <= 1'b0;
         fetch_count    <= '0;
      end else begin
         case (state)
            ST_FETCH: begin
               if (redirect_valid) begin
                  pc           <= redirect_pc;
                  if_id_valid  <= 1'b0;
                  if_id_inst   <= BUBBLE_INST;
                  halt_pending <= 1'b0;
                  if (!i_ready) begin
                     req_addr <= pc;
                  end
               end else if (halt) begin
                  if_id_valid <= 1'b0;
                  if_id_inst  <= BUBBLE_INST;
                  if (!i_ready) begin
                     req_addr     <= pc;
                     halt_pending <= 1'b1;
                  end
               end else if (i_ready) begin
                  pc <= pc_plus1;
                  if (stall) begin
                     hold_inst <= i_data;
                     hold_pc1  <= pc_plus1;
                  end else begin
                     if_id_inst     <= i_data;
                     if_id_pc_plus1 <= pc_plus1;
                     if_id_valid    <= 1'b1;
                     fetch_count    <= fetch_count + 16'd1;
                  end
               end
            end
            ST_HOLD: begin
               if (redirect_valid) begin
                  pc           <= redirect_pc;
                  if_id_valid  <= 1'b0;
                  if_id_inst   <= BUBBLE_INST;
                  halt_pending <= 1'b0;
               end else if (halt) begin
                  if_id_valid <= 1'b0;
                  if_id_inst  <= BUBBLE_INST;
               end else if (!stall) begin
                  if_id_inst     <= hold_inst;
                  if_id_pc_plus1 <= hold_pc1;
                  if_id_valid    <= 1'b1;
                  fetch_count    <= fetch_count + 16'd1;
               end
            end
            ST_SQUASH: begin
               if (redirect_valid) begin
                  pc           <= redirect_pc;
                  if_id_valid  <= 1'b0;
                  if_id_inst   <= BUBBLE_INST;
                  halt_pending <= 1'b0;
               end else if (halt) begin
                  if_id_valid  <= 1'b0;
                  if_id_inst   <= BUBBLE_INST;
                  halt_pending <= 1'b1;
               end
            end
            default: begin
               // HALTED: everything frozen until reset.
            end
         endcase
      end
   end

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Self-checking bench for if_id_fetch_stage with a latency-programmable
// instruction memory returning mem[a] = 16'h4000 + a.
module tb_if_id_fetch_stage;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        i_readM;
   logic [15:0] i_address;
   logic [15:0] i_data;
   logic        i_ready;
   logic        stall;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic        halt;
   logic [15:0] if_id_inst;
   logic [15:0] if_id_pc_plus1;
   logic        if_id_valid;
   logic [15:0] fetch_count;
   logic        halted;

   int          lat = 1;
   logic [7:0]  wc;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   if_id_fetch_stage #(
      .WORD_W      (16),
      .RESET_PC    (16'h0000),
      .BUBBLE_INST (16'hF01C)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .i_readM        (i_readM),
      .i_address      (i_address),
      .i_data         (i_data),
      .i_ready        (i_ready),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt           (halt),
      .if_id_inst     (if_id_inst),
      .if_id_pc_plus1 (if_id_pc_plus1),
      .if_id_valid    (if_id_valid),
      .fetch_count    (fetch_count),
      .halted         (halted)
   );

   // Memory model: ready in the lat-th cycle of a request.
   assign i_ready = i_readM && (int'(wc) == lat - 1);
   assign i_data  = 16'h4000 + i_address;

   always @(posedge clk) begin
      if (!reset_n || !i_readM || i_ready) wc <= 8'd0;
      else                                 wc <= wc + 8'd1;
   end

   typedef struct {
      logic        stall;
      logic        rv;
      logic [15:0] rpc;
      logic        halt;
      logic        e_valid;
      logic [15:0] e_inst;
      logic [15:0] e_pc1;
      logic [15:0] e_cnt;
      logic        e_readM;
      logic [15:0] e_addr;
      logic        e_halted;
   } vec_t;

   vec_t tbl[11];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock; also checks the memory address did not move mid-request.
   task automatic tick();
      logic        pend;
      logic [15:0] a;
      pend = i_readM && !i_ready;
      a    = i_address;
      @(posedge clk);
      #1;
      if (pend && reset_n) chk("addr_stable", i_address, a);
   endtask

   task automatic clear_in();
      stall          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 16'h0000;
      halt           = 1'b0;
   endtask

   task automatic do_reset();
      clear_in();
      reset_n = 1'b0;
      tick();
      tick();
      chk("rst_valid", 16'(if_id_valid), 16'h0);
      chk("rst_inst", if_id_inst, 16'hF01C);
      chk("rst_pc1", if_id_pc_plus1, 16'h0000);
      chk("rst_cnt", fetch_count, 16'h0000);
      chk("rst_halted", 16'(halted), 16'h0);
      chk("rst_readM", 16'(i_readM), 16'h0);
      reset_n = 1'b1;
      #1;
      chk("rst_addr", i_address, 16'h0000);
      chk("rst_readM_rel", 16'(i_readM), 16'h1);
   endtask

   task automatic wait_inst(input string name, input logic [15:0] inst);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         tick();
         if (if_id_valid && if_id_inst == inst) found = 1'b1;
      end
      chk(name, 16'(found), 16'h1);
   endtask

   initial begin
      //          stall rv    rpc       halt   val   inst      pc1       cnt     readM addr      halted
      tbl[0]  = '{1'b0, 1'b0, 16'h0000, 1'b0,  1'b1, 16'h4000, 16'h0001, 16'd1,  1'b1, 16'h0001, 1'b0};
      tbl[1]  = '{1'b0, 1'b0, 16'h0000, 1'b0,  1'b1, 16'h4001, 16'h0002, 16'd2,  1'b1, 16'h0002, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 16'h0000, 1'b0,  1'b1, 16'h4002, 16'h0003, 16'd3,  1'b1, 16'h0003, 1'b0};
      tbl[3]  = '{1'b0, 1'b0, 16'h0000, 1'b0,  1'b1, 16'h4003, 16'h0004, 16'd4,  1'b1, 16'h0004, 1'b0};
      tbl[4]  = '{1'b1, 1'b0, 16'h0000, 1'b0,  1'b1, 16'h4003, 16'h0004, 16'd4,  1'b0, 16'h0000, 1'b0};
      tbl[5]  = '{1'b1, 1'b0, 16'h0000, 1'b0,  1'b1, 16'h4003, 16'h0004, 16'd4,  1'b0, 16'h0000, 1'b0};
      tbl[6]  = '{1'b0, 1'b0, 16'h0000, 1'b0,  1'b1, 16'h4004, 16'h0005, 16'd5,  1'b1, 16'h0005, 1'b0};
      tbl[7]  = '{1'b1, 1'b1, 16'h0020, 1'b0,  1'b0, 16'hF01C, 16'h0000, 16'd5,  1'b1, 16'h0020, 1'b0};
      tbl[8]  = '{1'b0, 1'b0, 16'h0000, 1'b0,  1'b1, 16'h4020, 16'h0021, 16'd6,  1'b1, 16'h0021, 1'b0};
      tbl[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1,  1'b0, 16'hF01C, 16'h0000, 16'd6,  1'b0, 16'h0000, 1'b1};
      tbl[10] = '{1'b1, 1'b1, 16'h0050, 1'b1,  1'b0, 16'hF01C, 16'h0000, 16'd6,  1'b0, 16'h0000, 1'b1};

      // Table: single-cycle memory, back-to-back fetch, stall/hold, redirect, halt.
      lat = 1;
      do_reset();
      for (int v = 0; v < 11; v++) begin
         stall          = tbl[v].stall;
         redirect_valid = tbl[v].rv;
         redirect_pc    = tbl[v].rpc;
         halt           = tbl[v].halt;
         tick();
         clear_in();
         chk($sformatf("v%0d_valid", v), 16'(if_id_valid), 16'(tbl[v].e_valid));
         chk($sformatf("v%0d_inst", v), if_id_inst, tbl[v].e_inst);
         if (tbl[v].e_valid) chk($sformatf("v%0d_pc1", v), if_id_pc_plus1, tbl[v].e_pc1);
         chk($sformatf("v%0d_cnt", v), fetch_count, tbl[v].e_cnt);
         chk($sformatf("v%0d_readM", v), 16'(i_readM), 16'(tbl[v].e_readM));
         if (tbl[v].e_readM) chk($sformatf("v%0d_addr", v), i_address, tbl[v].e_addr);
         chk($sformatf("v%0d_halted", v), 16'(halted), 16'(tbl[v].e_halted));
      end

      // Latency 3, stall arriving with the word for pc=2.
      do_reset();
      lat = 3;
      wait_inst("s2_reach_4001", 16'h4001);
      chk("s2_addr_c1", i_address, 16'h0002);
      tick();
      chk("s2_addr_c2", i_address, 16'h0002);
      chk("s2_inst_c2", if_id_inst, 16'h4001);
      tick();
      chk("s2_addr_c3", i_address, 16'h0002);
      stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("s2_hold_readM", 16'(i_readM), 16'h0);
         chk("s2_hold_inst", if_id_inst, 16'h4001);
         chk("s2_hold_valid", 16'(if_id_valid), 16'h1);
      end
      stall = 1'b0;
      tick();
      chk("s2_rel_inst", if_id_inst, 16'h4002);
      chk("s2_rel_pc1", if_id_pc_plus1, 16'h0003);
      chk("s2_rel_cnt", fetch_count, 16'd3);
      chk("s2_rel_readM", 16'(i_readM), 16'h1);
      chk("s2_rel_addr", i_address, 16'h0003);

      // Redirect in the 2nd wait cycle of the request at pc=5.
      wait_inst("s3_reach_4004", 16'h4004);
      chk("s3_addr5", i_address, 16'h0005);
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 16'h0040;
      tick();
      clear_in();
      chk("s3_sq_valid", 16'(if_id_valid), 16'h0);
      chk("s3_sq_inst", if_id_inst, 16'hF01C);
      chk("s3_sq_readM", 16'(i_readM), 16'h1);
      chk("s3_sq_addr", i_address, 16'h0005);
      tick();
      chk("s3_post_addr", i_address, 16'h0040);
      chk("s3_post_valid", 16'(if_id_valid), 16'h0);
      chk("s3_post_cnt", fetch_count, 16'd5);
      wait_inst("s3_reach_4040", 16'h4040);
      chk("s3_pc1", if_id_pc_plus1, 16'h0041);
      chk("s3_cnt", fetch_count, 16'd6);

      // Halt with the request at pc=7 outstanding, then reset recovery.
      lat = 1;
      do_reset();
      for (int i = 0; i < 7; i++) tick();
      chk("s5_cnt7", fetch_count, 16'd7);
      chk("s5_addr7", i_address, 16'h0007);
      lat = 3;
      tick();
      halt = 1'b1;
      tick();
      halt = 1'b0;
      chk("s5_sq_readM", 16'(i_readM), 16'h1);
      chk("s5_sq_addr", i_address, 16'h0007);
      chk("s5_sq_valid", 16'(if_id_valid), 16'h0);
      chk("s5_sq_halted", 16'(halted), 16'h0);
      tick();
      chk("s5_halted", 16'(halted), 16'h1);
      chk("s5_readM", 16'(i_readM), 16'h0);
      for (int i = 0; i < 4; i++) begin
         redirect_valid = (i % 2 == 0);
         redirect_pc    = 16'h0100;
         stall          = (i % 2 == 1);
         tick();
         clear_in();
         chk("s5_frz_halted", 16'(halted), 16'h1);
         chk("s5_frz_readM", 16'(i_readM), 16'h0);
         chk("s5_frz_valid", 16'(if_id_valid), 16'h0);
         chk("s5_frz_cnt", fetch_count, 16'd7);
      end
      lat = 1;
      reset_n = 1'b0;
      tick();
      chk("s5_rst_halted", 16'(halted), 16'h0);
      chk("s5_rst_cnt", fetch_count, 16'd0);
      reset_n = 1'b1;
      #1;
      chk("s5_rst_addr", i_address, 16'h0000);
      tick();
      chk("s5_restart_inst", if_id_inst, 16'h4000);
      chk("s5_restart_valid", 16'(if_id_valid), 16'h1);

      // PC and fetch_count wrap.
      lat = 1;
      do_reset();
      redirect_valid = 1'b1;
      redirect_pc    = 16'hFFFE;
      tick();
      clear_in();
      chk("s6_addr", i_address, 16'hFFFE);
      chk("s6_valid0", 16'(if_id_valid), 16'h0);
      tick();
      chk("s6_inst_fffe", if_id_inst, 16'h3FFE);
      chk("s6_pc1_fffe", if_id_pc_plus1, 16'hFFFF);
      tick();
      chk("s6_inst_ffff", if_id_inst, 16'h3FFF);
      chk("s6_pc1_wrap", if_id_pc_plus1, 16'h0000);
      chk("s6_cnt2", fetch_count, 16'd2);
      chk("s6_addr_wrap", i_address, 16'h0000);
      for (int i = 0; i < 65534; i++) tick();
      chk("s6_cnt_wrap", fetch_count, 16'h0000);
      chk("s6_last_pc1", if_id_pc_plus1, 16'hFFFE);
      chk("s6_last_inst", if_id_inst, 16'h3FFD);
      chk("s6_last_valid", 16'(if_id_valid), 16'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
